// File: rtl/l1_pkg.sv
// +------------------------------------------------------------------+
// | l1_pkg : shared types and constants for the layer-1 sequencer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package l1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } l1_seq_state_t;

  localparam int L1_POOL_PIX = 169;
  localparam int L1_WIN_PIX  = 121;
  localparam int L1_GRP_GAP  = 5;
  localparam int L1_CNT_W    = 8;

endpackage

`default_nettype wire

// File: rtl/l1_frame_seq_if.sv
// +------------------------------------------------------------------+
// | l1_frame_seq_if : handshake bundle between the sequencer and its |
// | conv / layer_1 / downstream neighbours.  Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

interface l1_frame_seq_if #(
  parameter int CNT_W = 8
);

  logic             frm_start;
  logic             abort;
  logic             grp_rdy;
  logic             ds_bsy;
  logic             win_done;
  logic             grp_ack;
  logic             pool_strt;
  logic             l1_bsy_in;
  logic             tx_done;
  logic             frame_busy;
  logic [CNT_W-1:0] pool_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             err;

  modport master (
    output frm_start, abort, grp_rdy, ds_bsy, win_done,
    input  grp_ack, pool_strt, l1_bsy_in, tx_done, frame_busy,
           pool_cnt, win_cnt, err
  );

  modport slave (
    input  frm_start, abort, grp_rdy, ds_bsy, win_done,
    output grp_ack, pool_strt, l1_bsy_in, tx_done, frame_busy,
           pool_cnt, win_cnt, err
  );

endinterface

`default_nettype wire

// File: rtl/l1_gap_timer.sv
// +------------------------------------------------------------------+
// | l1_gap_timer : 3-bit loadable down-counter that paces strt.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module l1_gap_timer #(
  parameter logic [2:0] LOAD_VAL = 3'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != 3'd0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign zero = (r_cnt == 3'd0);

endmodule

`default_nettype wire

// File: rtl/l1_frame_seq.sv
// +------------------------------------------------------------------+
// | l1_frame_seq : frame sequencer pacing pool groups into layer_1   |
// | and counting pooled pixels / consumed windows.  Rev 1.0          |
// +------------------------------------------------------------------+
`default_nettype none

module l1_frame_seq
  import l1_pkg::*;
#(
  parameter int POOL_PIX = L1_POOL_PIX,
  parameter int WIN_PIX  = L1_WIN_PIX,
  parameter int GRP_GAP  = L1_GRP_GAP,
  parameter int CNT_W    = L1_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  l1_frame_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_POOL_MAX  = CNT_W'(POOL_PIX);
  localparam logic [CNT_W-1:0] c_POOL_LAST = CNT_W'(POOL_PIX - 1);
  localparam logic [CNT_W-1:0] c_WIN_MAX   = CNT_W'(WIN_PIX);
  localparam logic [CNT_W-1:0] c_WIN_LAST  = CNT_W'(WIN_PIX - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  l1_seq_state_t    r_state;
  l1_seq_state_t    w_next;
  logic [CNT_W-1:0] r_pool_cnt;
  logic [CNT_W-1:0] r_win_cnt;
  logic             r_err;
  logic             w_ack;
  logic             w_start;
  logic             w_win_inc;
  logic             w_win_final;
  logic             w_err_set;
  logic             w_gap_zero;

  l1_gap_timer #(
    .LOAD_VAL (3'(GRP_GAP - 1))
  ) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_ack),
    .zero (w_gap_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ack       = 1'b0;
    w_start     = 1'b0;
    w_win_inc   = 1'b0;
    w_win_final = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        w_err_set = bus.win_done;
        if (bus.frm_start) begin
          w_start = 1'b1;
          w_next  = FILL;
        end
      end
      FILL, DRAIN: begin
        // abort suppresses the ack in the very cycle it is seen
        w_ack = (r_state == FILL) && bus.grp_rdy && w_gap_zero &&
                !bus.abort && (r_pool_cnt != c_POOL_MAX);
        if (bus.win_done) begin
          if (r_win_cnt == c_WIN_MAX) begin
            w_err_set = 1'b1;
          end else begin
            w_win_inc   = 1'b1;
            w_win_final = (r_win_cnt == c_WIN_LAST);
          end
        end
        if (bus.abort || w_win_final) begin
          w_next = DONE;
        end else if (w_ack && (r_pool_cnt == c_POOL_LAST)) begin
          w_next = DRAIN;
        end
      end
      DONE: begin
        w_err_set = bus.win_done;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // counters hold through DONE/IDLE so the frame totals stay readable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pool_cnt <= '0;
      r_win_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_pool_cnt <= '0;
      end else if (w_ack) begin
        r_pool_cnt <= r_pool_cnt + c_ONE;
      end

      if (w_start) begin
        r_win_cnt <= '0;
      end else if (w_win_inc) begin
        r_win_cnt <= r_win_cnt + c_ONE;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_start) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.grp_ack    = w_ack;
  assign bus.pool_strt  = w_ack;
  assign bus.tx_done    = (r_state == DONE);
  assign bus.frame_busy = (r_state == FILL) || (r_state == DRAIN);
  assign bus.l1_bsy_in  = bus.ds_bsy || (r_state == IDLE) || (r_state == DONE);
  assign bus.pool_cnt   = r_pool_cnt;
  assign bus.win_cnt    = r_win_cnt;
  assign bus.err        = r_err;

endmodule

`default_nettype wire
